// File: rtl/bypass_hazard_unit_pkg.sv
// Shared constants for the execute bypass / decode hazard block.
package bypass_hazard_unit_pkg;

  typedef logic [1:0] fwd_sel_t;

  // Operand source select presented to the EX stage.
  localparam fwd_sel_t FWD_RF   = 2'b00;  // register file read
  localparam fwd_sel_t FWD_WB   = 2'b01;  // producer now in WB
  localparam fwd_sel_t FWD_MEM  = 2'b10;  // producer now in MEM
  localparam fwd_sel_t FWD_HOLD = 2'b11;  // WB value held for non write-through RF

  // Tag control bits alongside the address: valid, we, is_load.
  localparam int unsigned TAG_CTRL_W = 3;

  localparam int unsigned REG_ZERO   = 0;   // hardwired zero, never forwards
  localparam int unsigned REG_STATUS = 30;  // exception/status writes target this register

endpackage

// File: rtl/bypass_port_match.sv
// One source operand compared against the EX/MEM/WB destination tags.
module bypass_port_match
  import bypass_hazard_unit_pkg::*;
#(
  parameter int unsigned AW               = 5,
  parameter int unsigned RF_WRITE_THROUGH = 1
) (
  input  logic [AW-1:0] src_addr,
  input  logic          src_used,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_addr,
  input  logic          ex_is_load,
  input  logic          mem_valid,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic          wb_valid,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  output fwd_sel_t      sel,
  output logic          load_use
);

  logic src_live, ex_hit, mem_hit, wb_hit;

  // Youngest producer wins; a load still in EX has no data yet and forces a stall instead.
  always_comb begin
    src_live = src_used & (src_addr != AW'(REG_ZERO));
    ex_hit   = src_live & ex_valid & ex_we & (ex_addr == src_addr);
    mem_hit  = src_live & mem_valid & mem_we & (mem_addr == src_addr);
    wb_hit   = src_live & wb_valid & wb_we & (wb_addr == src_addr);
    load_use = ex_hit & ex_is_load;
    sel      = FWD_RF;
    if (ex_hit && !ex_is_load) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end else if (wb_hit && (RF_WRITE_THROUGH == 0)) begin
      sel = FWD_HOLD;
    end
  end

endmodule

// File: rtl/bypass_hazard_unit.sv
// Shadow destination-tag pipeline, registered bypass selects and decode stall generation.
module bypass_hazard_unit
  import bypass_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned AW               = 5,
  parameter int unsigned RF_WRITE_THROUGH = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NUM_PORTS*AW-1:0] id_src_addr,
  input  logic [NUM_PORTS-1:0]   id_src_used,
  input  logic                   id_dst_we,
  input  logic [AW-1:0]          id_dst_addr,
  input  logic                   id_is_load,
  input  logic                   id_is_md,
  input  logic                   pipe_stall,
  input  logic                   flush,
  input  logic                   md_done,
  output logic [2*NUM_PORTS-1:0] ex_fwd_sel,
  output logic                   hazard_stall,
  output logic                   md_busy
);

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic          is_load;
  } tag_t;

  localparam int unsigned TagW = AW + TAG_CTRL_W;

  tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag;
  logic [2*NUM_PORTS-1:0] sel_q, sel_d, sel_comb;
  logic [NUM_PORTS-1:0]   load_use, md_src_hit;
  logic                   md_pending_q, md_pending_d;
  logic [AW-1:0]          md_addr_q, md_addr_d;
  logic                   md_wait, md_raw, md_struct, md_issue;
  logic [TagW-1:0]        unused_wb_tag;

  // WB is the last shadow stage; only its we/addr feed the match logic.
  assign unused_wb_tag = wb_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    bypass_port_match #(
      .AW              (AW),
      .RF_WRITE_THROUGH(RF_WRITE_THROUGH)
    ) u_match (
      .src_addr  (id_src_addr[p*AW +: AW]),
      .src_used  (id_src_used[p]),
      .ex_valid  (ex_q.valid),
      .ex_we     (ex_q.we),
      .ex_addr   (ex_q.addr),
      .ex_is_load(ex_q.is_load),
      .mem_valid (mem_q.valid),
      .mem_we    (mem_q.we),
      .mem_addr  (mem_q.addr),
      .wb_valid  (wb_q.valid),
      .wb_we     (wb_q.we),
      .wb_addr   (wb_q.addr),
      .sel       (sel_comb[2*p +: 2]),
      .load_use  (load_use[p])
    );
  end

  // Decode-stage hazard detection; a retiring mult/div releases its dependants this cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      md_src_hit[p] = id_src_used[p] & (id_src_addr[p*AW +: AW] == md_addr_q);
    end
    md_wait      = md_pending_q & ~md_done;
    md_raw       = md_wait & ((|md_src_hit) | (id_dst_we & (id_dst_addr == md_addr_q)));
    md_struct    = md_wait & id_is_md;
    hazard_stall = id_valid & ~flush & ((|load_use) | md_raw | md_struct);
    md_issue     = id_valid & id_is_md & ~flush & ~pipe_stall & ~hazard_stall;
    // Mult/div results return via md_done, so they never forward from the pipe.
    id_tag.valid   = id_valid;
    id_tag.we      = id_dst_we & ~id_is_md;
    id_tag.addr    = id_dst_addr;
    id_tag.is_load = id_is_load;
  end

  // Next-state for tag pipe, selects and scoreboard; flush beats pipe_stall beats hazard.
  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    sel_d        = sel_q;
    md_pending_d = md_pending_q;
    md_addr_d    = md_addr_q;
    if (flush || !pipe_stall) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush || hazard_stall) begin
        ex_d  = '0;
        sel_d = '0;
      end else begin
        ex_d  = id_tag;
        sel_d = sel_comb;
      end
      if (md_done) begin
        md_pending_d = 1'b0;
      end
      if (md_issue) begin
        md_pending_d = 1'b1;
        md_addr_d    = id_dst_addr;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      sel_q        <= '0;
      md_pending_q <= 1'b0;
      md_addr_q    <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      sel_q        <= sel_d;
      md_pending_q <= md_pending_d;
      md_addr_q    <= md_addr_d;
    end
  end

  assign ex_fwd_sel = sel_q;
  assign md_busy    = md_pending_q;

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Directed bench: write-through instance plus a WB-hold instance sharing the same stimulus.
module tb_bypass_hazard_unit;
  import bypass_hazard_unit_pkg::*;

  logic       clock, reset;
  logic       id_valid, id_dst_we, id_is_load, id_is_md;
  logic [9:0] id_src_addr;
  logic [1:0] id_src_used;
  logic [4:0] id_dst_addr;
  logic       pipe_stall, flush, md_done;
  logic [3:0] sel_wt, sel_nwt;
  logic       stall_wt, stall_nwt, busy_wt, busy_nwt;

  int n_vec = 0;
  int n_err = 0;

  bypass_hazard_unit #(.NUM_PORTS(2), .AW(5), .RF_WRITE_THROUGH(1)) u_wt (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .pipe_stall(pipe_stall), .flush(flush),
    .md_done(md_done), .ex_fwd_sel(sel_wt), .hazard_stall(stall_wt), .md_busy(busy_wt)
  );

  bypass_hazard_unit #(.NUM_PORTS(2), .AW(5), .RF_WRITE_THROUGH(0)) u_nwt (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .pipe_stall(pipe_stall), .flush(flush),
    .md_done(md_done), .ex_fwd_sel(sel_nwt), .hazard_stall(stall_nwt), .md_busy(busy_nwt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one decode instruction: src0, src1, used mask, dst, we, load, mult/div.
  task automatic drive(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] used, input logic [4:0] d, input logic we,
                       input logic ld, input logic md);
    id_valid    = v;
    id_src_addr = {a1, a0};
    id_src_used = used;
    id_dst_addr = d;
    id_dst_we   = we;
    id_is_load  = ld;
    id_is_md    = md;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; pipe_stall = 1'b0; flush = 1'b0; md_done = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_sel", sel_wt, 4'b0000);
    check("rst_stall", stall_wt, 1'b0);
    check("rst_busy", busy_wt, 1'b0);
    check("rst_sel_nwt", sel_nwt, 4'b0000);
    reset = 1'b0;
    tick();

    // Back-to-back ALU dependency: both operands from MEM.
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0); #1;
    check("alu_stall", stall_wt, 1'b0);
    tick();
    check("alu_sel", sel_wt, 4'b1010);
    check("alu_sel_nwt", sel_nwt, 4'b1010);
    drain();

    // Load, nop, reader: port0 from WB, r0 port never forwards.
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0); #1;
    check("ld_gap_stall", stall_wt, 1'b0);
    tick();
    check("ld_gap_sel", sel_wt, 4'b0001);
    drain();

    // Load-use: one stall cycle, bubble, then forward from WB.
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    check("lu_stall", stall_wt, 1'b1);
    tick();
    check("lu_bubble_sel", sel_wt, 4'b0000);
    check("lu_stall_clear", stall_wt, 1'b0);
    tick();
    check("lu_sel", sel_wt, 4'b0001);
    drain();

    // Mult/div RAW: stall until md_done, then issue with RF select.
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1); #1;
    check("md_issue_stall", stall_wt, 1'b0);
    tick();
    check("md_busy_set", busy_wt, 1'b1);
    drive(1'b1, 5'd9, 5'd2, 2'b11, 5'd1, 1'b1, 1'b0, 1'b0); #1;
    check("md_raw_stall0", stall_wt, 1'b1);
    tick();
    check("md_raw_stall1", stall_wt, 1'b1);
    check("md_raw_bubble", sel_wt, 4'b0000);
    tick();
    check("md_raw_stall2", stall_wt, 1'b1);
    md_done = 1'b1; #1;
    check("md_done_stall", stall_wt, 1'b0);
    tick();
    md_done = 1'b0;
    check("md_busy_clr", busy_wt, 1'b0);
    check("md_raw_sel", sel_wt, 4'b0000);
    drain();

    // Structural hazard; md_done and a new issue on the same edge.
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0, 1'b1); #1;
    check("md_struct_stall", stall_wt, 1'b1);
    tick();
    check("md_struct_busy", busy_wt, 1'b1);
    md_done = 1'b1; #1;
    check("md_struct_release", stall_wt, 1'b0);
    tick();
    md_done = 1'b0;
    check("md_reissue_busy", busy_wt, 1'b1);
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    check("md_old_addr", stall_wt, 1'b0);
    drive(1'b1, 5'd10, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    check("md_new_addr", stall_wt, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    md_done = 1'b1; tick(); md_done = 1'b0;
    check("md_busy_clr2", busy_wt, 1'b0);
    drain();

    // pipe_stall freezes selects and tags; flush with pipe_stall still empties EX.
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ps_hold_sel%0d", i), sel_wt, 4'b1010);
    end
    pipe_stall = 1'b0;
    drive(1'b1, 5'd4, 5'd3, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    check("ps_tags_held", sel_wt, 4'b0110);
    flush = 1'b1; pipe_stall = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check("flush_sel", sel_wt, 4'b0000);
    flush = 1'b0; pipe_stall = 1'b0;
    tick();
    check("flush_ex_inv", sel_wt, 4'b0101);
    drain();

    // Writer in WB while reader decodes: hold select only without write-through.
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd12, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 5'd12, 5'd12, 2'b11, 5'd13, 1'b1, 1'b0, 1'b0); tick();
    check("wb_hold_nwt", sel_nwt, 4'b1111);
    check("wb_hold_wt", sel_wt, 4'b0000);
    drain();

    // Reset during a load-use stall with pipe_stall also high.
    drive(1'b1, 5'd0, 5'd0, 2'b00, REG_STATUS[4:0], 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0); tick();
    check("pre_rst_sel", sel_wt, 4'b0010);
    drive(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    check("pre_rst_stall", stall_wt, 1'b1);
    check("pre_rst_busy", busy_wt, 1'b1);
    reset = 1'b1; pipe_stall = 1'b1;
    tick();
    check("mid_rst_sel", sel_wt, 4'b0000);
    check("mid_rst_busy", busy_wt, 1'b0);
    check("mid_rst_stall", stall_wt, 1'b0);
    check("mid_rst_sel_nwt", sel_nwt, 4'b0000);
    check("mid_rst_busy_nwt", busy_nwt, 1'b0);
    check("mid_rst_stall_nwt", stall_nwt, 1'b0);
    reset = 1'b0; pipe_stall = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bypass_hazard_unit.md
Name: bypass_hazard_unit

Overview:
- Parametrised successor to the per-operand execute bypass select logic.
- Holds a shadow pipeline of destination tags (EX/MEM/WB) plus a multicycle mult/div scoreboard.
- Computes forwarding selects for NUM_PORTS operands at the ID->EX boundary and registers them.
- Raises the decode stall for load-use, mult/div RAW/WAW and mult/div structural hazards; sits beside the decode/execute latches of the 5-stage core.

Parameters:
NUM_PORTS, 2, number of source operands tracked per instruction
AW, 5, register address width; register 0 never matches
RF_WRITE_THROUGH, 1, 1 = register file returns same-cycle WB data; 0 = use WB-hold select 2'b11

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
id_valid  in  1  decode slot holds a real instruction
id_src_addr  in  NUM_PORTS*AW  decode source addresses, port p at [p*AW +: AW]
id_src_used  in  NUM_PORTS  source p is actually read
id_dst_we  in  1  decode instruction writes a register
id_dst_addr  in  AW  resolved destination (exception/status writes already presented as r30)
id_is_load  in  1  decode instruction is lw
id_is_md  in  1  decode instruction is mult/div (result via md_done, not via pipe)
pipe_stall  in  1  external freeze (memory wait); all state holds
flush  in  1  squash decode and EX (taken branch/jump)
md_done  in  1  mult/div result writes register file this cycle
ex_fwd_sel  out  2*NUM_PORTS  registered select for EX operand p: 00 RF, 01 WB, 10 MEM, 11 WB-hold
hazard_stall  out  1  combinational; freeze PC and IF/ID, bubble into EX
md_busy  out  1  scoreboard pending bit

Behaviour:
- Reset: all tags invalid, ex_fwd_sel=0, md pending=0, md_busy=0. Reset overrides flush and pipe_stall.
- Tag = {valid, we, addr, is_load}. A tag "matches" src a when valid & we & addr==a & a!=0 and the source is used.
- Select computation for port p, in priority order (MEM wins over WB):
  - match vs EX tag (non-load) -> 10;
  - else match vs MEM tag -> 01;
  - else match vs WB tag and RF_WRITE_THROUGH==0 -> 11;
  - else 00.
- hazard_stall = id_valid & ~flush & any of:
  - a used source matches the EX tag with is_load=1;
  - md pending & ~md_done & a used source or the destination equals md_addr;
  - id_is_md & md pending & ~md_done.
- Clock edge, no reset:
  - flush=1: EX tag invalid, ex_fwd_sel=0; MEM<-EX and WB<-MEM still advance; no md issue.
  - else pipe_stall=1: every register holds, including ex_fwd_sel and md state.
  - else hazard_stall=1: EX gets bubble (invalid, sel 0); MEM<-EX, WB<-MEM.
  - else: EX<-decode tag, ex_fwd_sel<-computed selects, MEM<-EX, WB<-MEM.
- An mult/div instruction enters EX with we=0 (it never forwards from the pipe). On that same edge: pending=1, md_addr=id_dst_addr.
- md_done clears pending. If md_done and a new mult/div issue occur in the same cycle, set wins and md_addr is loaded with the new address.
- md_done while not pending: ignored.
- md_busy = pending register.

Decomposition:
- Shared package: FWD_RF/FWD_WB/FWD_MEM/FWD_HOLD select constants, tag struct/field widths, REG_ZERO, REG_STATUS (30).
- One sub-module: bypass_port_match (one operand vs three tags -> 2-bit select), instantiated NUM_PORTS times via generate.

Test Plan:
- add r3 then add r4,r3,r3 back-to-back -> next edge ex_fwd_sel=10/10, hazard_stall=0.
- lw r5; nop; sub r6,r5,r0 -> sub's port0 sel=01, port1=00 (r0 never forwards).
- lw r7 then add r8,r7,r2 -> hazard_stall=1 for exactly one cycle, EX bubble sel=00; following edge add enters with port0 sel=01.
- mul r9 issue, then add r1,r9,r2 -> stall until md_done; in the md_done cycle stall=0, add issues with sel=00. Repeat with mul r9 followed by mul r10 -> structural stall; same-cycle md_done + issue leaves md_busy=1 with md_addr=10.
- pipe_stall held 3 cycles mid-forward -> ex_fwd_sel and tags unchanged; flush asserted together with pipe_stall -> EX tag invalid, sel=00.
- RF_WRITE_THROUGH=0 variant: writer now in WB while reader is in decode -> sel=11. Reset asserted mid-stall -> all outputs 0 on the next edge.
